// File: rtl/demux4_stream.sv
// 1-to-4 packet demultiplexer with a one-entry register per output lane.
// Optional per-lane packet counters are enabled by DEMUX4_STREAM_PKTCNT_EN.
module demux4_stream #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [1:0]       sel,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic [WIDTH-1:0] out2_data,
    output logic [WIDTH-1:0] out3_data,
    output logic [3:0]       out_last,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic             busy
`ifdef DEMUX4_STREAM_PKTCNT_EN
    ,
    output logic [31:0]      pkt_count
`endif
);

    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       lane_q, lane_d;
    logic [1:0]       act;
    logic             xfer;
    logic [WIDTH-1:0] data_q [LANES];
    logic [LANES-1:0] valid_q;
    logic [LANES-1:0] last_q;

    // Lane selection, handshake and packet-boundary tracking.
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        act      = sel;
        if (state_q == BUSY) begin
            act = lane_q;
        end
        in_ready = !valid_q[act] || out_ready[act];
        xfer     = in_valid && in_ready;
        case (state_q)
            IDLE: begin
                if (xfer && !in_last) begin
                    state_d = BUSY;
                    lane_d  = sel;
                end
            end
            BUSY: begin
                if (xfer && in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
        end
    end

    // Per-lane output register: a load wins over a drain so a full lane
    // can accept a new beat in the same cycle its old one leaves.
    for (genvar n = 0; n < LANES; n++) begin : g_lane
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q[n]  <= '0;
                last_q[n]  <= 1'b0;
                valid_q[n] <= 1'b0;
            end else if (xfer && (act == 2'(n))) begin
                data_q[n]  <= in_data;
                last_q[n]  <= in_last;
                valid_q[n] <= 1'b1;
            end else if (valid_q[n] && out_ready[n]) begin
                valid_q[n] <= 1'b0;
            end
        end

`ifdef DEMUX4_STREAM_PKTCNT_EN
        logic [CNT_W-1:0] cnt_q;

        // Counts packets whose last beat has left the lane; wraps naturally.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (valid_q[n] && out_ready[n] && last_q[n]) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign pkt_count[CNT_W*n +: CNT_W] = cnt_q;
`endif
    end

    assign out0_data = data_q[0];
    assign out1_data = data_q[1];
    assign out2_data = data_q[2];
    assign out3_data = data_q[3];
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_demux4_stream.sv
// Bench for demux4_stream: directed scenarios plus a randomized run
// checked against per-lane FIFO queues of expected beats.
module tb_demux4_stream;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic [1:0] sel;
    logic       in_ready;
    logic [7:0] out0_data, out1_data, out2_data, out3_data;
    logic [3:0] out_last;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic       busy;
`ifdef DEMUX4_STREAM_PKTCNT_EN
    logic [31:0] pkt_count;
`endif

    logic [7:0] od [4];
    int passed;
    int total;

    demux4_stream #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .sel       (sel),
        .in_ready  (in_ready),
        .out0_data (out0_data),
        .out1_data (out1_data),
        .out2_data (out2_data),
        .out3_data (out3_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef DEMUX4_STREAM_PKTCNT_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    assign od[0] = out0_data;
    assign od[1] = out1_data;
    assign od[2] = out2_data;
    assign od[3] = out3_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [7:0] d, input logic l,
                         input logic [1:0] s, input logic [3:0] r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        sel       = s;
        out_ready = r;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive(1'b0, 8'h00, 1'b0, 2'd0, 4'hF);
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        drive(1'b1, 8'hAA, 1'b1, 2'd2, 4'h0);
        rst = 1'b1;
        tick();
        total++; if (out_valid !== 4'b0000) $display("FAIL reset_valid: got %b expected 0000", out_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (out_last !== 4'b0000) $display("FAIL reset_last: got %b expected 0000", out_last); else passed++;
        total++; if ({out0_data, out1_data, out2_data, out3_data} !== 32'h0)
            $display("FAIL reset_data: got %h expected 00000000", {out0_data, out1_data, out2_data, out3_data}); else passed++;
        drive(1'b0, 8'h00, 1'b0, 2'd0, 4'hF);
        rst = 1'b0;
    endtask

    task automatic test_single;
        drive(1'b1, 8'h5A, 1'b1, 2'd2, 4'hF);
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL single_ready: got %b expected 1", in_ready); else passed++;
        tick();
        total++; if (out2_data !== 8'h5A) $display("FAIL single_data: got %h expected 5a", out2_data); else passed++;
        total++; if (out_valid !== 4'b0100) $display("FAIL single_valid: got %b expected 0100", out_valid); else passed++;
        total++; if (out_last[2] !== 1'b1) $display("FAIL single_last: got %b expected 1", out_last[2]); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL single_busy: got %b expected 0", busy); else passed++;
        drive(1'b0, 8'h00, 1'b0, 2'd0, 4'hF);
        tick();
        total++; if (out_valid !== 4'b0000) $display("FAIL single_drain: got %b expected 0000", out_valid); else passed++;
    endtask

    task automatic test_sel_lock;
        drive(1'b1, 8'h01, 1'b0, 2'd1, 4'hF);
        tick();
        total++; if (out1_data !== 8'h01 || out_valid !== 4'b0010)
            $display("FAIL lock_beat1: got %h/%b expected 01/0010", out1_data, out_valid); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL lock_busy1: got %b expected 1", busy); else passed++;
        drive(1'b1, 8'h02, 1'b0, 2'd3, 4'hF);
        tick();
        total++; if (out1_data !== 8'h02 || out_valid !== 4'b0010)
            $display("FAIL lock_beat2: got %h/%b expected 02/0010", out1_data, out_valid); else passed++;
        drive(1'b1, 8'h03, 1'b1, 2'd3, 4'hF);
        tick();
        total++; if (out1_data !== 8'h03 || out_valid !== 4'b0010 || out_last[1] !== 1'b1)
            $display("FAIL lock_beat3: got %h/%b/%b expected 03/0010/1", out1_data, out_valid, out_last[1]); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL lock_busy3: got %b expected 0", busy); else passed++;
        drive(1'b0, 8'h00, 1'b0, 2'd0, 4'hF);
        tick();
    endtask

    task automatic test_backpressure;
        drive(1'b1, 8'h10, 1'b1, 2'd0, 4'h0);
        tick();
        drive(1'b1, 8'h20, 1'b1, 2'd0, 4'h0);
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL bp_stall_ready: got %b expected 0", in_ready); else passed++;
        tick();
        total++; if (out0_data !== 8'h10 || out_valid !== 4'b0001)
            $display("FAIL bp_hold: got %h/%b expected 10/0001", out0_data, out_valid); else passed++;
        drive(1'b1, 8'h20, 1'b1, 2'd0, 4'b0001);
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", in_ready); else passed++;
        tick();
        total++; if (out0_data !== 8'h20 || out_valid !== 4'b0001)
            $display("FAIL bp_reload: got %h/%b expected 20/0001", out0_data, out_valid); else passed++;
        drive(1'b0, 8'h00, 1'b0, 2'd0, 4'hF);
        tick();
    endtask

    task automatic test_independent;
        drive(1'b1, 8'h33, 1'b1, 2'd3, 4'h0);
        tick();
        drive(1'b1, 8'h11, 1'b1, 2'd1, 4'h0);
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL indep_ready: got %b expected 1", in_ready); else passed++;
        tick();
        total++; if (out1_data !== 8'h11 || out3_data !== 8'h33 || out_valid !== 4'b1010)
            $display("FAIL indep_lanes: got %h/%h/%b expected 11/33/1010", out1_data, out3_data, out_valid); else passed++;
        drive(1'b0, 8'h00, 1'b0, 2'd0, 4'hF);
        tick();
        total++; if (out_valid !== 4'b0000) $display("FAIL indep_drain: got %b expected 0000", out_valid); else passed++;
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 8'h41, 1'b0, 2'd2, 4'hF);
        tick();
        drive(1'b1, 8'h42, 1'b0, 2'd0, 4'hF);
        tick();
        total++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", busy); else passed++;
        drive(1'b1, 8'h43, 1'b0, 2'd0, 4'hF);
        rst = 1'b1;
        tick();
        total++; if (busy !== 1'b0 || out_valid !== 4'b0000)
            $display("FAIL midrst_clear: got %b/%b expected 0/0000", busy, out_valid); else passed++;
        drive(1'b1, 8'h44, 1'b1, 2'd3, 4'hF);
        rst = 1'b0;
        tick();
        total++; if (out3_data !== 8'h44 || out_valid !== 4'b1000 || busy !== 1'b0)
            $display("FAIL midrst_first_beat: got %h/%b/%b expected 44/1000/0", out3_data, out_valid, busy); else passed++;
        drive(1'b0, 8'h00, 1'b0, 2'd0, 4'hF);
        tick();
    endtask

`ifdef DEMUX4_STREAM_PKTCNT_EN
    task automatic test_pktcnt;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 8'(i), 1'b1, 2'd0, 4'hF);
            tick();
        end
        total++; if (pkt_count !== 32'h0000_00FF) $display("FAIL pktcnt_255: got %h expected 000000ff", pkt_count); else passed++;
        drive(1'b0, 8'h00, 1'b0, 2'd0, 4'hF);
        tick();
        total++; if (pkt_count !== 32'h0) $display("FAIL pktcnt_wrap: got %h expected 00000000", pkt_count); else passed++;
    endtask
`endif

    // Randomized traffic: each lane is a capacity-1 FIFO of {last, data}.
    task automatic test_random;
        logic [8:0]  mq [4][$];
        logic [8:0]  front;
        int unsigned m_cnt [4];
        bit          m_busy;
        logic [1:0]  m_lane;
        logic [1:0]  a;
        bit          exp_rdy;
        bit          hold;
        do_reset();
        m_busy = 1'b0;
        m_lane = 2'd0;
        hold   = 1'b0;
        for (int n = 0; n < 4; n++) m_cnt[2'(n)] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom);
                in_last  = ($urandom_range(0, 2) == 0);
                sel      = 2'($urandom);
            end
            out_ready = 4'($urandom) | 4'($urandom);
            #1;
            a       = m_busy ? m_lane : sel;
            exp_rdy = (mq[a].size() == 0) || out_ready[a];
            total++; if (in_ready !== exp_rdy) $display("FAIL rnd_ready c=%0d: got %b expected %b", c, in_ready, exp_rdy); else passed++;
            total++; if (busy !== m_busy) $display("FAIL rnd_busy c=%0d: got %b expected %b", c, busy, m_busy); else passed++;
            for (int n = 0; n < 4; n++) begin
                total++;
                if (out_valid[2'(n)] !== (mq[2'(n)].size() != 0))
                    $display("FAIL rnd_valid c=%0d lane=%0d: got %b expected %b", c, n, out_valid[2'(n)], mq[2'(n)].size() != 0);
                else passed++;
                if (mq[2'(n)].size() != 0) begin
                    front = mq[2'(n)][0];
                    total++;
                    if ({out_last[2'(n)], od[2'(n)]} !== front)
                        $display("FAIL rnd_beat c=%0d lane=%0d: got %h expected %h", c, n, {out_last[2'(n)], od[2'(n)]}, front);
                    else passed++;
                end
`ifdef DEMUX4_STREAM_PKTCNT_EN
                total++;
                if (pkt_count[8*n +: 8] !== 8'(m_cnt[2'(n)]))
                    $display("FAIL rnd_pktcnt c=%0d lane=%0d: got %0d expected %0d", c, n, pkt_count[8*n +: 8], m_cnt[2'(n)]);
                else passed++;
`endif
            end
            for (int n = 0; n < 4; n++) begin
                if (mq[2'(n)].size() != 0 && out_ready[2'(n)]) begin
                    front = mq[2'(n)].pop_front();
                    if (front[8]) m_cnt[2'(n)] = (m_cnt[2'(n)] + 1) % 256;
                end
            end
            if (in_valid && exp_rdy) begin
                mq[a].push_back({in_last, in_data});
                if (!m_busy && !in_last) begin
                    m_busy = 1'b1;
                    m_lane = sel;
                end else if (m_busy && in_last) begin
                    m_busy = 1'b0;
                end
            end
            hold = in_valid && !exp_rdy;
        end
        drive(1'b0, 8'h00, 1'b0, 2'd0, 4'hF);
        tick();
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        sel       = 2'd0;
        out_ready = 4'h0;
        test_reset();
        test_single();
        test_sel_lock();
        test_backpressure();
        test_independent();
        test_reset_mid();
`ifdef DEMUX4_STREAM_PKTCNT_EN
        test_pktcnt();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
